// File: rtl/nl_traffic_source_arb_pkg.sv
// Shared NoC types for the traffic-source arbiter: flit and FIFO flag
// layouts plus the arbiter FSM encoding.
package nl_traffic_source_arb_pkg;

    localparam int FLIT_PAYLOAD_W = 16;

    typedef struct packed {
        logic                      head;
        logic                      tail;
        logic [FLIT_PAYLOAD_W-1:0] payload;
    } flit_t;

    typedef struct packed {
        logic full;
        logic empty;
    } fifo_flags_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } arb_state_e;

    // Width of a source index; never below one bit.
    function automatic int ptr_w(int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nl_traffic_source_arb_if.sv
// Bundle of source-FIFO, injection-port and credit signals seen by the arbiter.
interface nl_traffic_source_arb_if #(
    parameter int N_SRC = 4
) ();
    import nl_traffic_source_arb_pkg::*;

    fifo_flags_t [N_SRC-1:0] src_flags;
    flit_t       [N_SRC-1:0] src_data;
    logic        [N_SRC-1:0] src_pop;
    flit_t                   out_flit;
    logic                    out_valid;
    logic                    credit_in;

    modport master (
        output src_flags, src_data, credit_in,
        input  src_pop, out_flit, out_valid
    );

    modport slave (
        input  src_flags, src_data, credit_in,
        output src_pop, out_flit, out_valid
    );

endinterface

// File: rtl/nl_traffic_source_arb_rr_pick.sv
// Rotating-priority first-one finder: returns the first set req bit at or
// after ptr, wrapping modulo N_SRC.
module nl_traffic_source_arb_rr_pick #(
    parameter int N_SRC = 4,
    parameter int GW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic [N_SRC-1:0] req,
    input  logic [GW-1:0]    ptr,
    output logic [GW-1:0]    idx,
    output logic             any
);

    logic [N_SRC-1:0] hit;
    logic [GW-1:0]    cand [N_SRC];

    // cand[gi] is the source gi places after ptr; ptr < N_SRC keeps the
    // single conditional subtraction sufficient for the wrap.
    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_cand
        logic [GW:0] sum;
        assign sum       = {1'b0, ptr} + (GW+1)'(gi);
        assign cand[gi]  = (sum >= (GW+1)'(N_SRC)) ? GW'(sum - (GW+1)'(N_SRC)) : sum[GW-1:0];
        assign hit[gi]   = req[cand[gi]];
    end

    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N_SRC - 1; k >= 0; k--) begin
            if (hit[k]) begin
                idx = cand[k];
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/nl_traffic_source_arb.sv
// Packet-atomic round-robin arbiter from N_SRC source FIFOs onto one
// credit-flow-controlled network injection port.
module nl_traffic_source_arb #(
    parameter int N_SRC   = 4,
    parameter int CREDITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    nl_traffic_source_arb_if.slave bus
);
    import nl_traffic_source_arb_pkg::*;

    localparam int GW = ptr_w(N_SRC);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [CW-1:0] CREDITS_INIT = CW'(CREDITS);

    arb_state_e       state_q, state_d;
    logic [GW-1:0]    gnt_q, gnt_d;
    logic [GW-1:0]    gnt_ptr_q, gnt_ptr_d;
    logic [CW-1:0]    credit_cnt_q, credit_cnt_d;
    logic             out_valid_q, out_valid_d;
    flit_t            out_flit_q, out_flit_d;

    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] full_flags;
    logic             unused_full;
    logic [GW-1:0]    pick_idx;
    logic             pick_any;
    logic             pop_en;
    logic [N_SRC-1:0] pop_vec;
    flit_t            gnt_flit;

    for (genvar gi = 0; gi < N_SRC; gi++) begin : g_req
        assign req[gi]        = ~bus.src_flags[gi].empty;
        assign full_flags[gi] = bus.src_flags[gi].full;
    end
    assign unused_full = ^full_flags;

    nl_traffic_source_arb_rr_pick #(
        .N_SRC (N_SRC),
        .GW    (GW)
    ) u_pick (
        .req (req),
        .ptr (gnt_ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    // The pop depends only on registered credit state, so credit_in never
    // reaches src_pop in the same cycle.
    always_comb begin
        gnt_flit     = bus.src_data[gnt_q];
        pop_en       = (state_q == ST_ACTIVE) && req[gnt_q] && (credit_cnt_q != '0);
        state_d      = state_q;
        gnt_d        = gnt_q;
        gnt_ptr_d    = gnt_ptr_q;
        credit_cnt_d = credit_cnt_q;
        out_valid_d  = pop_en;
        out_flit_d   = out_flit_q;
        pop_vec      = '0;

        if (pop_en) begin
            pop_vec[gnt_q] = 1'b1;
            out_flit_d     = gnt_flit;
        end

        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d   = pick_idx;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (pop_en && gnt_flit.tail) begin
                    state_d   = ST_IDLE;
                    gnt_ptr_d = (gnt_q == GW'(N_SRC - 1)) ? '0 : gnt_q + GW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        case ({pop_en, bus.credit_in})
            2'b10:   credit_cnt_d = credit_cnt_q - CW'(1);
            2'b01:   credit_cnt_d = credit_cnt_q + CW'(1);
            default: credit_cnt_d = credit_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            gnt_ptr_q    <= '0;
            credit_cnt_q <= CREDITS_INIT;
            out_valid_q  <= 1'b0;
            out_flit_q   <= '0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gnt_ptr_q    <= gnt_ptr_d;
            credit_cnt_q <= credit_cnt_d;
            out_valid_q  <= out_valid_d;
            out_flit_q   <= out_flit_d;
        end
    end

    assign bus.src_pop   = pop_vec;
    assign bus.out_valid = out_valid_q;
    assign bus.out_flit  = out_flit_q;

    a_credit_max:   assert property (@(posedge clk) disable iff (!rst_n) credit_cnt_q <= CREDITS_INIT);
    a_credit_ovf:   assert property (@(posedge clk) disable iff (!rst_n) !(bus.credit_in && credit_cnt_q == CREDITS_INIT));
    a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n) (pop_vec & ~req) == '0);
    a_pop_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(pop_vec));

endmodule

// File: tb/tb_nl_traffic_source_arb.sv
// Bench for the traffic-source arbiter: bench-owned FIFO queues, a per-cycle
// credit/ownership/latency model, and directed packet scenarios.
module tb_nl_traffic_source_arb;
    import nl_traffic_source_arb_pkg::*;

    localparam int N  = 4;
    localparam int CR = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    nl_traffic_source_arb_if #(.N_SRC(N)) bus ();

    nl_traffic_source_arb #(.N_SRC(N), .CREDITS(CR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int       n_cmp = 0;
    int       n_bad = 0;
    int       cyc   = 0;
    flit_t    fq [N][$];
    int       exp_order[$];
    int       credit_cyc[$];
    int       pop_cyc[$];
    int       pop_src[$];
    int       val_cyc[$];
    logic [N-1:0] pop_seen = '0;
    bit       auto_credit = 1'b0;
    int       ec[8];
    int       es[8];

    // Model state: credits owed downstream, packet ownership, expected output.
    int       exp_credit  = CR;
    bit       exp_valid   = 1'b0;
    flit_t    exp_flit    = '0;
    bit       owner_valid = 1'b0;
    int       owner       = 0;
    bit       last_tail   = 1'b0;

    function automatic void chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic flit_t mk(int s, int k, bit h, bit t);
        flit_t f;
        f.head    = h;
        f.tail    = t;
        f.payload = 16'((s << 8) | (k + 1));
        return f;
    endfunction

    always @(negedge clk) begin
        int    idx;
        bit    any;
        flit_t pf;
        cyc++;
        if (!rst_n) begin
            chk("rst_out_valid", int'(bus.out_valid), 0);
            chk("rst_src_pop", int'(bus.src_pop), 0);
            exp_credit  = CR;
            exp_valid   = 1'b0;
            exp_flit    = '0;
            owner_valid = 1'b0;
            last_tail   = 1'b0;
            pop_seen    = '0;
        end else begin
            chk("out_valid", int'(bus.out_valid), int'(exp_valid));
            if (exp_valid) chk("out_flit", int'(bus.out_flit), int'(exp_flit));
            if (bus.out_valid) begin
                val_cyc.push_back(cyc);
                $display("tb: cyc %0d flit payload=%h head=%0b tail=%0b",
                         cyc, bus.out_flit.payload, bus.out_flit.head, bus.out_flit.tail);
            end
            chk("credit_cnt", int'(dut.credit_cnt_q), exp_credit);
            chk("pop_onehot0", ($countones(bus.src_pop) <= 1) ? 1 : 0, 1);
            any = 1'b0;
            idx = 0;
            pf  = '0;
            for (int i = 0; i < N; i++) begin
                if (bus.src_pop[i]) begin
                    any = 1'b1;
                    idx = i;
                end
            end
            if (any) begin
                pf = bus.src_data[idx];
                pop_cyc.push_back(cyc);
                pop_src.push_back(idx);
                chk("pop_nonempty", int'(bus.src_flags[idx].empty), 0);
                chk("pop_credit", (exp_credit > 0) ? 1 : 0, 1);
                if (owner_valid) begin
                    chk("pop_owner", idx, owner);
                end else begin
                    chk("pkt_bubble", int'(last_tail), 0);
                    if (exp_order.size() > 0) chk("pkt_order", idx, exp_order.pop_front());
                    else chk("pkt_unexpected", idx, -1);
                    owner_valid = 1'b1;
                    owner       = idx;
                end
                if (pf.tail) owner_valid = 1'b0;
            end else if (owner_valid) begin
                chk("stall_reason", (bus.src_flags[owner].empty || exp_credit == 0) ? 1 : 0, 1);
            end
            last_tail  = any && pf.tail;
            exp_valid  = any;
            if (any) exp_flit = pf;
            exp_credit = exp_credit + int'(bus.credit_in) - (any ? 1 : 0);
            pop_seen   = bus.src_pop;
        end
    end

    task automatic drive();
        bit cr;
        for (int i = 0; i < N; i++) begin
            bus.src_flags[i].full  = 1'b0;
            bus.src_flags[i].empty = (fq[i].size() == 0);
            bus.src_data[i]        = (fq[i].size() > 0) ? fq[i][0] : '0;
        end
        cr = auto_credit && rst_n && (pop_seen != '0);
        foreach (credit_cyc[j]) if (credit_cyc[j] == cyc + 1) cr = 1'b1;
        bus.credit_in = cr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rst_n) begin
            for (int i = 0; i < N; i++)
                if (pop_seen[i] && fq[i].size() > 0) void'(fq[i].pop_front());
        end
        drive();
    endtask

    task automatic clear_logs();
        pop_cyc.delete();
        pop_src.delete();
        val_cyc.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) fq[i].delete();
        exp_order.delete();
        credit_cyc.delete();
        auto_credit = 1'b0;
        drive();
        step();
        step();
        rst_n = 1'b1;
        drive();
    endtask

    task automatic check_log(string nm, int t0, int n);
        chk({nm, "_pop_count"}, pop_src.size(), n);
        for (int i = 0; i < n && i < pop_src.size(); i++) begin
            chk({nm, "_pop_cycle"}, pop_cyc[i] - t0, ec[i]);
            chk({nm, "_pop_src"}, pop_src[i], es[i]);
        end
    endtask

    initial begin
        int t0;
        bus.src_flags = '0;
        bus.src_data  = '0;
        bus.credit_in = 1'b0;

        // All sources empty: nothing moves, credits stay full.
        do_reset();
        clear_logs();
        repeat (10) step();
        chk("t28_pops", pop_src.size(), 0);
        chk("t28_valids", val_cyc.size(), 0);
        chk("t28_credit", int'(dut.credit_cnt_q), CR);

        // One 3-flit packet on source 2, no credits returned.
        do_reset();
        exp_order = '{2};
        for (int k = 0; k < 3; k++) fq[2].push_back(mk(2, k, k == 0, k == 2));
        drive();
        clear_logs();
        t0 = cyc + 1;
        repeat (8) step();
        ec = '{1, 2, 3, 0, 0, 0, 0, 0};
        es = '{2, 2, 2, 0, 0, 0, 0, 0};
        check_log("t29", t0, 3);
        chk("t29_valid_count", val_cyc.size(), 3);
        if (val_cyc.size() > 0) chk("t29_valid_first", val_cyc[0] - t0, 2);
        chk("t29_credit", int'(dut.credit_cnt_q), 1);
        chk("t29_gnt_ptr", int'(dut.gnt_ptr_q), 3);
        chk("t29_order_done", exp_order.size(), 0);

        // Single-flit packets on 0,1,3 with immediate credit return; 0 refills.
        do_reset();
        auto_credit = 1'b1;
        exp_order = '{0, 1, 3, 0};
        fq[0].push_back(mk(0, 0, 1'b1, 1'b1));
        fq[1].push_back(mk(1, 0, 1'b1, 1'b1));
        fq[3].push_back(mk(3, 0, 1'b1, 1'b1));
        drive();
        clear_logs();
        t0 = cyc + 1;
        step();
        step();
        fq[0].push_back(mk(0, 1, 1'b1, 1'b1));
        drive();
        repeat (8) step();
        ec = '{1, 3, 5, 7, 0, 0, 0, 0};
        es = '{0, 1, 3, 0, 0, 0, 0, 0};
        check_log("t30", t0, 4);
        chk("t30_credit", int'(dut.credit_cnt_q), CR);
        chk("t30_order_done", exp_order.size(), 0);

        // 6-flit packet outruns 4 credits; single credit pulses release one pop each.
        do_reset();
        exp_order = '{0, 1};
        for (int k = 0; k < 6; k++) fq[0].push_back(mk(0, k, k == 0, k == 5));
        fq[1].push_back(mk(1, 0, 1'b1, 1'b1));
        drive();
        clear_logs();
        t0 = cyc + 1;
        credit_cyc = '{t0 + 7, t0 + 10, t0 + 12};
        repeat (7) step();
        chk("t31_credit_empty", int'(dut.credit_cnt_q), 0);
        repeat (9) step();
        ec = '{1, 2, 3, 4, 8, 11, 13, 0};
        es = '{0, 0, 0, 0, 0, 0, 1, 0};
        check_log("t31", t0, 7);
        chk("t31_order_done", exp_order.size(), 0);

        // Granted FIFO runs dry after the head; source 1 must wait for the tail.
        do_reset();
        auto_credit = 1'b1;
        exp_order = '{0, 1};
        fq[0].push_back(mk(0, 0, 1'b1, 1'b0));
        fq[1].push_back(mk(1, 0, 1'b1, 1'b1));
        drive();
        clear_logs();
        t0 = cyc + 1;
        repeat (5) step();
        fq[0].push_back(mk(0, 1, 1'b0, 1'b1));
        drive();
        repeat (5) step();
        ec = '{1, 5, 7, 0, 0, 0, 0, 0};
        es = '{0, 0, 1, 0, 0, 0, 0, 0};
        check_log("t32", t0, 3);
        chk("t32_gnt_ptr", int'(dut.gnt_ptr_q), 2);

        // Reset lands on the 2nd flit of a 4-flit packet from source 3.
        exp_order = '{3, 1, 3};
        for (int k = 0; k < 4; k++) fq[3].push_back(mk(3, k, k == 0, k == 3));
        drive();
        clear_logs();
        t0 = cyc + 1;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("t33_rst_src_pop", int'(bus.src_pop), 0);
        chk("t33_rst_out_valid", int'(bus.out_valid), 0);
        chk("t33_rst_out_flit", int'(bus.out_flit), 0);
        chk("t33_rst_credit", int'(dut.credit_cnt_q), CR);
        chk("t33_rst_gnt_ptr", int'(dut.gnt_ptr_q), 0);
        fq[1].push_back(mk(1, 0, 1'b1, 1'b1));
        drive();
        step();
        rst_n = 1'b1;
        drive();
        clear_logs();
        t0 = cyc + 1;
        repeat (10) step();
        ec = '{1, 3, 4, 5, 0, 0, 0, 0};
        es = '{1, 3, 3, 3, 0, 0, 0, 0};
        check_log("t33", t0, 4);
        chk("t33_order_done", exp_order.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/nl_traffic_source_arb.md
NL_TRAFFIC_SOURCE_ARB -- requirements
Module: NL_traffic_source_arb

Interface
REQ-001 Parameter N_SRC, default 4: number of source FIFOs arbitrated; legal range 2..16.
REQ-002 Parameter CREDITS, default 4: downstream input-buffer depth in flits; legal range 1..15.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 src_flags  input  fifo_flags_t[N_SRC]  per-source FIFO flags; only .empty is used.
REQ-006 src_data  input  flit_t[N_SRC]  per-source FIFO head entry, valid when !empty.
REQ-007 src_pop  output  N_SRC  one-hot-or-zero pop strobe to the source FIFOs.
REQ-008 out_flit  output  flit_t  registered flit toward the network injection port.
REQ-009 out_valid  output  1  out_flit is valid this cycle.
REQ-010 credit_in  input  1  one-cycle pulse; downstream freed one buffer slot.

Function
REQ-011 FSM states SHALL be IDLE and ACTIVE, plus a grant index gnt of width clog2(N_SRC).
REQ-012 In IDLE, the block SHALL pick the first source with !empty, searching gnt_ptr, gnt_ptr+1, ... modulo N_SRC; it SHALL register that source into gnt and enter ACTIVE next cycle; src_pop SHALL be 0 in IDLE.
REQ-013 In IDLE with all sources empty, the block SHALL stay in IDLE and leave gnt_ptr unchanged.
REQ-014 In ACTIVE, src_pop[gnt] SHALL be asserted combinationally when src_flags[gnt].empty==0 and credit_cnt>0; all other src_pop bits SHALL be 0.
REQ-015 Whenever src_pop[gnt] is asserted, out_flit SHALL take src_data[gnt] and out_valid SHALL be 1 on the next cycle: latency is 1 cycle from pop to valid.
REQ-016 When no pop is issued, out_valid SHALL be 0 on the next cycle and out_flit SHALL hold its value.
REQ-017 A pop of a flit with tail=1 SHALL return the FSM to IDLE and set gnt_ptr to (gnt+1) mod N_SRC. A single-flit packet (head=tail=1) SHALL be handled identically.
REQ-018 The grant SHALL be held for the whole packet: no other source is popped between head and tail, even if the granted FIFO goes empty mid-packet (the block stalls).
REQ-019 credit_cnt SHALL be clog2(CREDITS+1) bits wide: decrement by 1 on a pop, increment by 1 on credit_in, unchanged when both occur in the same cycle.
REQ-020 With credit_cnt==0, no pop SHALL issue. A credit_in arriving in that cycle SHALL enable a pop in the next cycle, not the same one.
REQ-021 Assertions: credit_cnt never exceeds CREDITS; credit_in never arrives while credit_cnt==CREDITS; src_pop is never asserted to an empty source; src_pop is at most one-hot.
REQ-022 Maximum throughput SHALL be 1 flit/cycle within a packet, with one IDLE bubble cycle between packets.

Reset
REQ-023 On rst_n low, asynchronously: state=IDLE, gnt=0, gnt_ptr=0, credit_cnt=CREDITS, out_valid=0, out_flit=0; src_pop SHALL be 0 while in reset.
REQ-024 Reset asserted mid-packet SHALL abandon the packet with no further pops. After release, arbitration restarts from source 0.

Structure
REQ-025 flit_t (with head and tail bits) and fifo_flags_t SHALL come from the shared NoC package; no new package types are required.
REQ-026 The block SHALL contain one sub-module, NL_rr_pick: a combinational rotating-priority first-one finder with inputs req[N_SRC] and ptr, and outputs idx and any.
REQ-027 All state SHALL be registered inside this module; there SHALL be no combinational path from credit_in to src_pop.

Verification
REQ-028 Reset, all sources empty for 10 cycles -> src_pop=0, out_valid=0, credit_cnt=4 throughout.
REQ-029 Source 2 holds a 3-flit packet, CREDITS=4, credit_in tied 0 -> IDLE 1 cycle; pops on 3 consecutive cycles; out_valid high for 3 cycles starting 1 cycle after the first pop; credit_cnt=1; gnt_ptr=3.
REQ-030 Sources 0, 1 and 3 each hold a 1-flit packet, credits are returned immediately -> service order 0,1,3 with one bubble between packets; then source 0 refills and is served after 3.
REQ-031 Source 0 holds a 6-flit packet, CREDITS=4, no credit_in -> 4 pops then a stall; a credit_in pulse at cycle t -> the 5th pop occurs at t+1; source 1 is never popped mid-packet.
REQ-032 Granted FIFO goes empty after the head flit while source 1 is non-empty -> stall with no pop to source 1 until source 0 supplies the tail.
REQ-033 rst_n is pulsed low on the 2nd flit of a 4-flit packet -> outputs clear immediately, credit_cnt=CREDITS, and the next grant goes to the lowest non-empty index from 0.
